// File: rtl/button_conditioner.sv
// Push-button front end: per channel a 2-flop synchroniser, a debounce/auto-repeat
// FSM, and Moore-decoded level (DPBs), press strobe (SCENs) and repeat strobe (MCENs).
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] PBs,
  output logic [N_BTN-1:0] DPBs,
  output logic [N_BTN-1:0] SCENs,
  output logic [N_BTN-1:0] MCENs
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CNT = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
  localparam cnt_t RD_LAST  = cnt_t'(REPEAT_DELAY - 1);
  localparam cnt_t RP_LAST  = cnt_t'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    FIRE,
    HOLD,
    RPULSE,
    REPEAT,
    WAIT_RELEASE
  } state_t;

  logic [N_BTN-1:0] sync_q1;
  logic [N_BTN-1:0] pb_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchroniser stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      pb_s    <= '0;
    end else begin
      sync_q1 <= PBs;
      pb_s    <= sync_q1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    state_t state, state_nxt;
    cnt_t   cnt, cnt_nxt;

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
        IDLE: begin
          if (pb_s[i]) state_nxt = WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (!pb_s[i])            state_nxt = IDLE;
          else if (cnt == DEB_LAST) state_nxt = FIRE;
          else                      cnt_nxt   = cnt + cnt_t'(1);
        end
        FIRE: state_nxt = HOLD;
        HOLD: begin
          if (!pb_s[i])            state_nxt = WAIT_RELEASE;
          else if (cnt == RD_LAST) state_nxt = RPULSE;
          else                     cnt_nxt   = cnt + cnt_t'(1);
        end
        RPULSE: state_nxt = pb_s[i] ? REPEAT : WAIT_RELEASE;
        REPEAT: begin
          if (!pb_s[i])            state_nxt = WAIT_RELEASE;
          else if (cnt == RP_LAST) state_nxt = RPULSE;
          else                     cnt_nxt   = cnt + cnt_t'(1);
        end
        WAIT_RELEASE: begin
          // A release bounce restarts the stable-low count without leaving the state.
          if (pb_s[i])              cnt_nxt   = '0;
          else if (cnt == DEB_LAST) state_nxt = IDLE;
          else                      cnt_nxt   = cnt + cnt_t'(1);
        end
        default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) cnt_nxt = '0;
    end

    assign DPBs[i]  = (state != IDLE) && (state != WAIT_PRESS);
    assign SCENs[i] = (state == FIRE);
    assign MCENs[i] = (state == FIRE) || (state == RPULSE);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with D=4, RD=10, RP=3; expected outputs are
// hand-derived per edge, counting the first edge that samples the new PBs as edge 1.
module tb_button_conditioner;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] PBs;
  logic [N-1:0] DPBs, SCENs, MCENs;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .PBs  (PBs),
    .DPBs (DPBs),
    .SCENs(SCENs),
    .MCENs(MCENs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int k,
                            input logic [N-1:0] e_dpb, input logic [N-1:0] e_scen,
                            input logic [N-1:0] e_mcen);
    check($sformatf("%s dpb k=%0d", tag, k), DPBs, e_dpb);
    check($sformatf("%s scen k=%0d", tag, k), SCENs, e_scen);
    check($sformatf("%s mcen k=%0d", tag, k), MCENs, e_mcen);
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    PBs = '0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1;
    PBs   = '0;
    repeat (3) tick();
    check_outs("reset", 0, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    tick();

    // Clean press on channel 0, high for edges 1..8; pb_s low after edge 10,
    // HOLD sees it at edge 11, WAIT_RELEASE lasts 4 cycles, IDLE after edge 15.
    PBs = 4'b0001;
    for (int k = 1; k <= 18; k++) begin
      tick();
      check_outs("clean", k,
                 (k >= 7 && k <= 14) ? 4'b0001 : 4'b0000,
                 (k == 7) ? 4'b0001 : 4'b0000,
                 (k == 7) ? 4'b0001 : 4'b0000);
      if (k == 8) PBs = 4'b0000;
    end
    idle(4);

    // Bouncy press on channel 1: samples 1,0,1,1,0 then steady 1 from edge 6,
    // so FIRE lands on edge 6+(4+3)-1 = 12.
    PBs = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_outs("bounce", k,
                 (k >= 12) ? 4'b0010 : 4'b0000,
                 (k == 12) ? 4'b0010 : 4'b0000,
                 (k == 12) ? 4'b0010 : 4'b0000);
      PBs = (k + 1 == 2 || k + 1 == 5) ? 4'b0000 : 4'b0010;
    end
    idle(14);
    check("bounce released", DPBs, 4'b0000);

    // Auto-repeat on channel 2: FIRE at 7, repeats at 7+11, then every 4.
    PBs = 4'b0100;
    for (int k = 1; k <= 47; k++) begin
      tick();
      check_outs("repeat", k,
                 (k >= 7) ? 4'b0100 : 4'b0000,
                 (k == 7) ? 4'b0100 : 4'b0000,
                 (k == 7 || (k >= 18 && (k - 18) % 4 == 0)) ? 4'b0100 : 4'b0000);
    end
    idle(14);
    check("repeat released", DPBs, 4'b0000);

    // Release bounce on channel 3: PBs high for edges 1..10, low 11-12, high 13,
    // low after; the bounce restarts the stable-low count, so IDLE after edge 19.
    PBs = 4'b1000;
    for (int k = 1; k <= 24; k++) begin
      tick();
      check_outs("relbounce", k,
                 (k >= 7 && k <= 18) ? 4'b1000 : 4'b0000,
                 (k == 7) ? 4'b1000 : 4'b0000,
                 (k == 7) ? 4'b1000 : 4'b0000);
      PBs = (k + 1 <= 10 || k + 1 == 13) ? 4'b1000 : 4'b0000;
    end
    idle(4);

    // All four channels pressed on the same edge.
    PBs = 4'b1111;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_outs("simul", k,
                 (k >= 7) ? 4'b1111 : 4'b0000,
                 (k == 7) ? 4'b1111 : 4'b0000,
                 (k == 7) ? 4'b1111 : 4'b0000);
    end
    idle(14);
    check("simul released", DPBs, 4'b0000);

    // Reset while channel 0 sits in REPEAT (RPULSE at 18, REPEAT from 19).
    PBs = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_outs("prerst", k,
                 (k >= 7) ? 4'b0001 : 4'b0000,
                 (k == 7) ? 4'b0001 : 4'b0000,
                 (k == 7 || k == 18) ? 4'b0001 : 4'b0000);
    end
    reset = 1'b1;
    tick();
    check_outs("midrst", 0, 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_outs("postrst", k,
                 (k >= 7) ? 4'b0001 : 4'b0000,
                 (k == 7) ? 4'b0001 : 4'b0000,
                 (k == 7) ? 4'b0001 : 4'b0000);
    end
    idle(14);
    check("postrst released", DPBs, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
